// File: rtl/wb_stage.sv
// wb_stage: registered writeback stage between the memory stage and the
// register-file write port. It selects the load result, the ALU result or the
// link address, and formats load data by lane, size and signedness. Loads may
// see variable data-memory latency, so they are held in WAIT_MEM until
// dmem_rvalid arrives.
//
// Handshake: a transfer happens on a rising edge where in_valid && in_ready
// are both high. in_ready depends only on registered state (high in IDLE). The
// producer keeps its payload stable while in_valid is high and in_ready is low.
// dmem_rvalid is a one-cycle pulse with no back-pressure. It is only meaningful
// in WAIT_MEM. In IDLE it is flagged as spurious and its data is dropped.
module wb_stage #(
  parameter int XLEN   = 32,  // 32 or 64
  parameter int PC_INC = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_wb_sel,
  input  logic            in_reg_we,
  input  logic [4:0]      in_rd_addr,
  input  logic [XLEN-1:0] in_alu_rd,
  input  logic [XLEN-1:0] in_pc,
  input  logic            in_mem_ld_signed,
  input  logic [1:0]      in_mem_access_size,
  input  logic [2:0]      in_mem_offset,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            busy,
  output logic            err_spurious
);

  localparam logic [1:0] SEL_LOAD = 2'b00;
  localparam logic [1:0] SEL_ALU  = 2'b01;
  localparam logic [1:0] SEL_LINK = 2'b10;

  // Two-state FSM. busy mirrors the state and serves as its debug view.
  typedef enum logic [0:0] {
    S_IDLE     = 1'b0,
    S_WAIT_MEM = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  // Load context held while the stage waits for memory data.
  logic       ld_reg_we;
  logic [4:0] ld_rd_addr;
  logic       ld_signed;
  logic [1:0] ld_size;
  logic [2:0] ld_offset;

  // Per-cycle events decoded from state and inputs.
  logic accept_nonload;
  logic accept_load;
  logic load_done;
  logic spurious_hit;

  // Datapath results.
  logic [XLEN-1:0] nl_result;
  logic [XLEN-1:0] ld_result;
  logic [1:0]      eff_size;
  logic [2:0]      eff_off;
  logic [XLEN-1:0] shifted;

  // State register: reset aborts any load in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: a load enters WAIT_MEM and leaves it on dmem_rvalid.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (in_valid && (in_wb_sel == SEL_LOAD)) begin
          state_nxt = S_WAIT_MEM;
        end
      end
      S_WAIT_MEM: begin
        if (dmem_rvalid) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs and event decode. in_ready is a function of state only.
  always_comb begin
    in_ready       = (state == S_IDLE);
    busy           = (state == S_WAIT_MEM);
    accept_nonload = (state == S_IDLE) && in_valid && (in_wb_sel != SEL_LOAD);
    accept_load    = (state == S_IDLE) && in_valid && (in_wb_sel == SEL_LOAD);
    load_done      = (state == S_WAIT_MEM) && dmem_rvalid;
    spurious_hit   = (state == S_IDLE) && dmem_rvalid;
  end

  // Non-load result mux. The link address wraps modulo 2^XLEN.
  always_comb begin
    case (in_wb_sel)
      SEL_ALU:  nl_result = in_alu_rd;
      SEL_LINK: nl_result = in_pc + XLEN'(PC_INC);
      default:  nl_result = '0;
    endcase
  end

  // Load formatting: align the offset down to the access size, shift the
  // selected lane to bit 0, then sign- or zero-extend the field to XLEN.
  // A 32-bit build has no doubleword lane and no offset bit 2.
  always_comb begin
    eff_size = ld_size;
    if ((XLEN == 32) && (ld_size == 2'b11)) begin
      eff_size = 2'b10;
    end
    case (eff_size)
      2'b00:   eff_off = ld_offset;
      2'b01:   eff_off = {ld_offset[2:1], 1'b0};
      2'b10:   eff_off = {ld_offset[2], 2'b00};
      default: eff_off = 3'b000;
    endcase
    if (XLEN == 32) begin
      eff_off[2] = 1'b0;
    end
    shifted = dmem_rdata >> {eff_off, 3'b000};
    case (eff_size)
      2'b00: ld_result = ld_signed ? XLEN'($signed(shifted[7:0]))
                                   : XLEN'(shifted[7:0]);
      2'b01: ld_result = ld_signed ? XLEN'($signed(shifted[15:0]))
                                   : XLEN'(shifted[15:0]);
      2'b10: ld_result = ld_signed ? XLEN'($signed(shifted[31:0]))
                                   : XLEN'(shifted[31:0]);
      default: ld_result = shifted;
    endcase
  end

  // Load hold register: captures the load context on acceptance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_reg_we  <= 1'b0;
      ld_rd_addr <= 5'd0;
      ld_signed  <= 1'b0;
      ld_size    <= 2'b00;
      ld_offset  <= 3'b000;
    end else if (accept_load) begin
      ld_reg_we  <= in_reg_we;
      ld_rd_addr <= in_rd_addr;
      ld_signed  <= in_mem_ld_signed;
      ld_size    <= in_mem_access_size;
      ld_offset  <= in_mem_offset;
    end
  end

  // Register-file write port: rf_we pulses for one cycle per completion.
  // Writes to x0 are suppressed, but address and data still update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_we    <= 1'b0;
      rf_waddr <= 5'd0;
      rf_wdata <= '0;
    end else begin
      rf_we <= 1'b0;
      if (accept_nonload) begin
        rf_we    <= in_reg_we && (in_rd_addr != 5'd0);
        rf_waddr <= in_rd_addr;
        rf_wdata <= nl_result;
      end else if (load_done) begin
        rf_we    <= ld_reg_we && (ld_rd_addr != 5'd0);
        rf_waddr <= ld_rd_addr;
        rf_wdata <= ld_result;
      end
    end
  end

  // Sticky flag for read data that arrives with no load outstanding.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_spurious <= 1'b0;
    end else if (spurious_hit) begin
      err_spurious <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: drives a 32-bit and a 64-bit wb_stage in lockstep from one
// 64-bit stimulus bus. The 32-bit instance sees the low halves. Expected
// register-file writes are queued when stimulus is driven and are popped when
// a DUT raises rf_we.
module tb_wb_stage;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic        in_valid;
  logic [1:0]  in_wb_sel;
  logic        in_reg_we;
  logic [4:0]  in_rd_addr;
  logic [63:0] in_alu_rd;
  logic [63:0] in_pc;
  logic        in_mem_ld_signed;
  logic [1:0]  in_mem_access_size;
  logic [2:0]  in_mem_offset;
  logic        dmem_rvalid;
  logic [63:0] dmem_rdata;

  // ---------------- DUT outputs ----------------
  logic        in_ready32, busy32, rf_we32, err32;
  logic [4:0]  rf_waddr32;
  logic [31:0] rf_wdata32;
  logic        in_ready64, busy64, rf_we64, err64;
  logic [4:0]  rf_waddr64;
  logic [63:0] rf_wdata64;

  wb_stage #(.XLEN(32), .PC_INC(4)) dut32 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready32),
    .in_wb_sel(in_wb_sel), .in_reg_we(in_reg_we), .in_rd_addr(in_rd_addr),
    .in_alu_rd(in_alu_rd[31:0]), .in_pc(in_pc[31:0]),
    .in_mem_ld_signed(in_mem_ld_signed), .in_mem_access_size(in_mem_access_size),
    .in_mem_offset(in_mem_offset),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata[31:0]),
    .rf_we(rf_we32), .rf_waddr(rf_waddr32), .rf_wdata(rf_wdata32),
    .busy(busy32), .err_spurious(err32)
  );

  wb_stage #(.XLEN(64), .PC_INC(4)) dut64 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready64),
    .in_wb_sel(in_wb_sel), .in_reg_we(in_reg_we), .in_rd_addr(in_rd_addr),
    .in_alu_rd(in_alu_rd), .in_pc(in_pc),
    .in_mem_ld_signed(in_mem_ld_signed), .in_mem_access_size(in_mem_access_size),
    .in_mem_offset(in_mem_offset),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .rf_we(rf_we64), .rf_waddr(rf_waddr64), .rf_wdata(rf_wdata64),
    .busy(busy64), .err_spurious(err64)
  );

  // ---------------- scoreboard ----------------
  // Entry layout: {rd_addr[4:0], data[63:0]}
  logic [68:0] exp_q32[$];
  logic [68:0] exp_q64[$];
  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference load formatter, written from the lane/size rules.
  function automatic logic [63:0] fmt_model(input logic [63:0] rd, input logic [1:0] sz,
                                            input logic [2:0] off, input logic sg, input bit is64);
    logic [63:0] w;
    logic [63:0] field;
    logic [63:0] mask;
    logic [1:0]  s;
    int nbytes;
    int lane;
    w = is64 ? rd : {32'h0, rd[31:0]};
    s = sz;
    if (!is64 && s == 2'b11) s = 2'b10;
    nbytes = 1 << s;
    lane   = is64 ? (int'(off) / nbytes) : (int'(off[1:0]) / nbytes);
    field  = w >> (lane * nbytes * 8);
    if (nbytes < 8) begin
      mask  = (64'd1 << (nbytes * 8)) - 64'd1;
      field = field & mask;
      if (sg && field[nbytes*8-1]) field = field | ~mask;
    end
    if (!is64) field = {32'h0, field[31:0]};
    return field;
  endfunction

  // Compare each write strobe against the head of the expected queue.
  always @(negedge clk) begin
    logic [68:0] e;
    if (!reset) begin
      if (rf_we32) begin
        if (exp_q32.size() == 0) check("w32_unexpected", {63'h0, rf_we32}, 64'h0);
        else begin
          e = exp_q32.pop_front();
          check("w32_addr", {59'h0, rf_waddr32}, {59'h0, e[68:64]});
          check("w32_data", {32'h0, rf_wdata32}, e[63:0]);
        end
      end
      if (rf_we64) begin
        if (exp_q64.size() == 0) check("w64_unexpected", {63'h0, rf_we64}, 64'h0);
        else begin
          e = exp_q64.pop_front();
          check("w64_addr", {59'h0, rf_waddr64}, {59'h0, e[68:64]});
          check("w64_data", rf_wdata64, e[63:0]);
        end
      end
    end
  end

  // Checks for a completion whose write is suppressed (x0 or reg_we=0).
  task automatic check_suppressed(input logic [4:0] rd, input logic [63:0] e32, input logic [63:0] e64);
    check("sup_we32", {63'h0, rf_we32}, 64'h0);
    check("sup_we64", {63'h0, rf_we64}, 64'h0);
    check("sup_addr32", {59'h0, rf_waddr32}, {59'h0, rd});
    check("sup_addr64", {59'h0, rf_waddr64}, {59'h0, rd});
    check("sup_data32", {32'h0, rf_wdata32}, e32);
    check("sup_data64", rf_wdata64, e64);
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    in_valid = 1'b0;
    in_wb_sel = 2'b01;
    in_reg_we = 1'b0;
    in_rd_addr = 5'd0;
    in_alu_rd = 64'h0;
    in_pc = 64'h0;
    in_mem_ld_signed = 1'b0;
    in_mem_access_size = 2'b00;
    in_mem_offset = 3'b000;
    dmem_rvalid = 1'b0;
    dmem_rdata = 64'h0;
  endtask

  // Non-load op (wb_sel 01/10/11): one accepting edge, no idle cycle after.
  task automatic send_nl(input logic [1:0] sel, input logic we, input logic [4:0] rd,
                         input logic [63:0] alu, input logic [63:0] pc);
    logic [63:0] e32;
    logic [63:0] e64;
    logic [31:0] pc32;
    check("nl_rdy32", {63'h0, in_ready32}, 64'h1);
    check("nl_rdy64", {63'h0, in_ready64}, 64'h1);
    pc32 = pc[31:0] + 32'd4;
    case (sel)
      2'b01:   begin e64 = alu;        e32 = {32'h0, alu[31:0]}; end
      2'b10:   begin e64 = pc + 64'd4; e32 = {32'h0, pc32};      end
      default: begin e64 = 64'h0;      e32 = 64'h0;              end
    endcase
    in_valid = 1'b1;
    in_wb_sel = sel;
    in_reg_we = we;
    in_rd_addr = rd;
    in_alu_rd = alu;
    in_pc = pc;
    if (we && rd != 5'd0) begin
      exp_q32.push_back({rd, e32});
      exp_q64.push_back({rd, e64});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (!(we && rd != 5'd0)) begin
      @(negedge clk);
      check_suppressed(rd, e32, e64);
    end
  endtask

  // Load: accept, wait 'delay' edges for dmem_rvalid, then verify the return to IDLE.
  // During the wait a non-load is offered on in_valid and must be ignored.
  task automatic send_ld(input logic sg, input logic [1:0] sz, input logic [2:0] off,
                         input logic we, input logic [4:0] rd, input logic [63:0] rdata,
                         input int delay);
    logic [63:0] e32;
    logic [63:0] e64;
    e32 = fmt_model(rdata, sz, off, sg, 1'b0);
    e64 = fmt_model(rdata, sz, off, sg, 1'b1);
    check("ld_rdy32", {63'h0, in_ready32}, 64'h1);
    check("ld_rdy64", {63'h0, in_ready64}, 64'h1);
    in_valid = 1'b1;
    in_wb_sel = 2'b00;
    in_reg_we = we;
    in_rd_addr = rd;
    in_mem_ld_signed = sg;
    in_mem_access_size = sz;
    in_mem_offset = off;
    @(posedge clk);
    #1;
    // Scramble the load fields so that the held copy must be used.
    in_mem_ld_signed = ~sg;
    in_mem_access_size = 2'($urandom_range(0, 3));
    in_mem_offset = 3'($urandom_range(0, 7));
    in_valid = 1'b1;
    in_wb_sel = 2'b01;
    in_reg_we = 1'b1;
    in_rd_addr = 5'd9;
    in_alu_rd = 64'hBAD0_BAD0_BAD0_BAD0;
    for (int i = 1; i < delay; i++) begin
      @(negedge clk);
      check("wait_busy32", {63'h0, busy32}, 64'h1);
      check("wait_busy64", {63'h0, busy64}, 64'h1);
      check("wait_rdy32", {63'h0, in_ready32}, 64'h0);
      check("wait_rdy64", {63'h0, in_ready64}, 64'h0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata = rdata;
    if (we && rd != 5'd0) begin
      exp_q32.push_back({rd, e32});
      exp_q64.push_back({rd, e64});
    end
    @(negedge clk);
    check("rv_busy32", {63'h0, busy32}, 64'h1);
    check("rv_busy64", {63'h0, busy64}, 64'h1);
    @(posedge clk);
    #1;
    dmem_rvalid = 1'b0;
    dmem_rdata = {$urandom, $urandom};
    @(negedge clk);
    check("done_rdy32", {63'h0, in_ready32}, 64'h1);
    check("done_rdy64", {63'h0, in_ready64}, 64'h1);
    check("done_busy32", {63'h0, busy32}, 64'h0);
    if (!(we && rd != 5'd0)) check_suppressed(rd, e32, e64);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    idle_inputs();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdy32", {63'h0, in_ready32}, 64'h1);
    check("rst_busy64", {63'h0, busy64}, 64'h0);
    check("rst_we32", {63'h0, rf_we32}, 64'h0);
    check("rst_addr64", {59'h0, rf_waddr64}, 64'h0);
    check("rst_data32", {32'h0, rf_wdata32}, 64'h0);
    check("rst_data64", rf_wdata64, 64'h0);
    check("rst_err32", {63'h0, err32}, 64'h0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // ALU op, then confirm rf_we drops after one cycle.
    send_nl(2'b01, 1'b1, 5'd5, 64'hA5A5A5A5_12345678, 64'h0);
    @(negedge clk);
    @(negedge clk);
    check("alu_we_drop32", {63'h0, rf_we32}, 64'h0);
    check("alu_we_drop64", {63'h0, rf_we64}, 64'h0);

    // Link address with wrap, then a plain one.
    send_nl(2'b10, 1'b1, 5'd1, 64'h0, 64'hFFFFFFFF_FFFFFFFC);
    send_nl(2'b10, 1'b1, 5'd1, 64'h0, 64'h100);
    send_nl(2'b11, 1'b1, 5'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0);

    // Back-to-back random non-loads, one per cycle.
    for (int i = 0; i < 20; i++) begin
      send_nl(2'($urandom_range(1, 3)), 1'b1, 5'($urandom_range(1, 31)),
              {$urandom, $urandom}, {$urandom, $urandom});
    end

    // Directed loads.
    send_ld(1'b1, 2'b00, 3'd3, 1'b1, 5'd10, 64'h13572468_80FF7F01, 3);
    send_ld(1'b0, 2'b00, 3'd3, 1'b1, 5'd11, 64'h13572468_80FF7F01, 3);
    send_ld(1'b1, 2'b01, 3'd2, 1'b1, 5'd12, 64'h0_80011234, 1);
    send_ld(1'b0, 2'b01, 3'd2, 1'b1, 5'd13, 64'h0_80011234, 2);
    send_ld(1'b1, 2'b01, 3'd3, 1'b1, 5'd14, 64'h0_80011234, 1);
    send_ld(1'b0, 2'b01, 3'd3, 1'b1, 5'd15, 64'h0_80011234, 1);
    send_ld(1'b0, 2'b10, 3'd0, 1'b1, 5'd16, 64'hDEADBEEF_80000000, 2);
    send_ld(1'b1, 2'b10, 3'd4, 1'b1, 5'd17, 64'hDEADBEEF_80000000, 2);
    send_ld(1'b1, 2'b11, 3'd5, 1'b1, 5'd18, 64'hFEDCBA98_76543210, 1);

    // Random loads over all sizes, offsets and latencies.
    for (int i = 0; i < 24; i++) begin
      send_ld(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
              1'b1, 5'($urandom_range(1, 31)), {$urandom, $urandom}, $urandom_range(1, 4));
    end

    // Suppressed writes.
    send_nl(2'b01, 1'b1, 5'd0, 64'h0000_0001_CAFE_F00D, 64'h0);
    send_nl(2'b01, 1'b0, 5'd7, 64'h0000_0002_0BAD_CAFE, 64'h0);
    send_ld(1'b1, 2'b00, 3'd1, 1'b0, 5'd8, 64'h0_0000_8000, 2);
    send_ld(1'b0, 2'b10, 3'd0, 1'b1, 5'd0, 64'h1111_2222_3333_4444, 1);

    // Reset during WAIT_MEM aborts the load; a late rvalid is then spurious.
    in_valid = 1'b1;
    in_wb_sel = 2'b00;
    in_reg_we = 1'b1;
    in_rd_addr = 5'd20;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("abort_busy32", {63'h0, busy32}, 64'h1);
    #2;
    reset = 1'b1;
    #1;
    check("abort_rdy32", {63'h0, in_ready32}, 64'h1);
    check("abort_rdy64", {63'h0, in_ready64}, 64'h1);
    check("abort_busy64", {63'h0, busy64}, 64'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_we32", {63'h0, rf_we32}, 64'h0);
    check("abort_we64", {63'h0, rf_we64}, 64'h0);
    check("abort_err32", {63'h0, err32}, 64'h0);
    dmem_rvalid = 1'b1;
    dmem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clk);
    #1;
    dmem_rvalid = 1'b0;
    @(negedge clk);
    check("spur_err32", {63'h0, err32}, 64'h1);
    check("spur_err64", {63'h0, err64}, 64'h1);
    check("spur_we32", {63'h0, rf_we32}, 64'h0);
    check("spur_rdy32", {63'h0, in_ready32}, 64'h1);

    // Normal traffic afterwards; the error flag must stay set.
    send_nl(2'b01, 1'b1, 5'd3, 64'h0000_0000_0000_0042, 64'h0);
    send_ld(1'b1, 2'b00, 3'd0, 1'b1, 5'd4, 64'h0000_0000_0000_00FE, 1);
    repeat (3) @(negedge clk);
    check("sticky_err32", {63'h0, err32}, 64'h1);
    check("sticky_err64", {63'h0, err64}, 64'h1);
    check("q32_empty", 64'(exp_q32.size()), 64'h0);
    check("q64_empty", 64'(exp_q64.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
